// File: rtl/umi2axilite.sv
// UMI device-side endpoint: replays single-word UMI read/write/posted requests
// as AXI-Lite master transactions and returns the matching UMI response.
module umi2axilite #(
   parameter int DW = 32,
   parameter int AW = 64,
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          udev_req_valid,
   output logic          udev_req_ready,
   input  logic [CW-1:0] udev_req_cmd,
   input  logic [AW-1:0] udev_req_dstaddr,
   input  logic [AW-1:0] udev_req_srcaddr,
   input  logic [DW-1:0] udev_req_data,
   output logic          udev_resp_valid,
   input  logic          udev_resp_ready,
   output logic [CW-1:0] udev_resp_cmd,
   output logic [AW-1:0] udev_resp_dstaddr,
   output logic [AW-1:0] udev_resp_srcaddr,
   output logic [DW-1:0] udev_resp_data,
   output logic          axi_awvalid,
   input  logic          axi_awready,
   output logic [31:0]   axi_awaddr,
   output logic [2:0]    axi_awprot,
   output logic          axi_wvalid,
   input  logic          axi_wready,
   output logic [31:0]   axi_wdata,
   output logic [3:0]    axi_wstrb,
   input  logic          axi_bvalid,
   output logic          axi_bready,
   input  logic [1:0]    axi_bresp,
   output logic          axi_arvalid,
   input  logic          axi_arready,
   output logic [31:0]   axi_araddr,
   output logic [2:0]    axi_arprot,
   input  logic          axi_rvalid,
   output logic          axi_rready,
   input  logic [31:0]   axi_rdata,
   input  logic [1:0]    axi_rresp
);

   typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP} state_t;

   localparam logic [4:0] REQ_READ   = 5'h01;
   localparam logic [4:0] REQ_WRITE  = 5'h03;
   localparam logic [4:0] REQ_POSTED = 5'h05;
   localparam logic [4:0] RESP_READ  = 5'h02;
   localparam logic [4:0] RESP_WRITE = 5'h04;
   localparam logic [1:0] DECERR     = 2'b11;

   function automatic logic [3:0] strb_of(input logic [2:0] size, input logic [1:0] a);
      case (size)
         3'd0:    strb_of = 4'b0001 << a;
         3'd1:    strb_of = 4'b0011 << a;
         default: strb_of = 4'hF;
      endcase
   endfunction

   // Align the addressed byte lane down to bit 0 and clear bytes beyond the request size.
   function automatic logic [31:0] rdata_of(input logic [31:0] d, input logic [2:0] size,
                                             input logic [1:0] a);
      logic [31:0] s;
      s = d >> {a, 3'b000};
      case (size)
         3'd0:    rdata_of = {24'h000000, s[7:0]};
         3'd1:    rdata_of = {16'h0000, s[15:0]};
         default: rdata_of = s;
      endcase
   endfunction

   function automatic logic [CW-1:0] resp_cmd_of(input logic is_read, input logic [2:0] size,
                                                  input logic [7:0] len, input logic [1:0] err);
      logic [CW-1:0] c;
      c        = '0;
      c[4:0]   = is_read ? RESP_READ : RESP_WRITE;
      c[7:5]   = size;
      c[15:8]  = len;
      c[22]    = 1'b1;
      c[26:25] = err;
      return c;
   endfunction

   state_t      state_r;
   logic [2:0]  size_r;
   logic [7:0]  len_r;
   logic [1:0]  lsb_r;
   logic        posted_r;

   logic [4:0]  req_op_s;
   logic [2:0]  req_size_s;
   logic [7:0]  req_len_s;
   logic        req_ok_s;
   logic        accept_s;
   logic        unused_s;

   assign req_op_s   = udev_req_cmd[4:0];
   assign req_size_s = udev_req_cmd[7:5];
   assign req_len_s  = udev_req_cmd[15:8];
   assign req_ok_s   = (req_len_s == 8'd0) && (req_size_s <= 3'd2);
   assign accept_s   = udev_req_valid && udev_req_ready;
   assign unused_s   = ^{udev_req_cmd[CW-1:16], udev_req_data};

   // Request/response sequencer; all handshake and payload outputs are registered here.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_r           <= IDLE;
         size_r            <= 3'd0;
         len_r             <= 8'd0;
         lsb_r             <= 2'd0;
         posted_r          <= 1'b0;
         udev_req_ready    <= 1'b0;
         udev_resp_valid   <= 1'b0;
         udev_resp_cmd     <= '0;
         udev_resp_dstaddr <= '0;
         udev_resp_srcaddr <= '0;
         udev_resp_data    <= '0;
         axi_awvalid       <= 1'b0;
         axi_awaddr        <= 32'd0;
         axi_awprot        <= 3'd0;
         axi_wvalid        <= 1'b0;
         axi_wdata         <= 32'd0;
         axi_wstrb         <= 4'd0;
         axi_bready        <= 1'b0;
         axi_arvalid       <= 1'b0;
         axi_araddr        <= 32'd0;
         axi_arprot        <= 3'd0;
         axi_rready        <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               udev_req_ready <= 1'b1;
               if (accept_s) begin
                  size_r   <= req_size_s;
                  len_r    <= req_len_s;
                  lsb_r    <= udev_req_dstaddr[1:0];
                  posted_r <= (req_op_s == REQ_POSTED);
                  case (req_op_s)
                     REQ_WRITE, REQ_POSTED: begin
                        if (req_ok_s) begin
                           udev_req_ready    <= 1'b0;
                           udev_resp_dstaddr <= udev_req_srcaddr;
                           udev_resp_srcaddr <= udev_req_dstaddr;
                           axi_awvalid       <= 1'b1;
                           axi_awaddr        <= udev_req_dstaddr[31:0];
                           axi_awprot        <= 3'd0;
                           axi_wvalid        <= 1'b1;
                           axi_wdata         <= udev_req_data[31:0] << {udev_req_dstaddr[1:0], 3'b000};
                           axi_wstrb         <= strb_of(req_size_s, udev_req_dstaddr[1:0]);
                           state_r           <= WRITE;
                        end else if (req_op_s == REQ_WRITE) begin
                           udev_req_ready    <= 1'b0;
                           udev_resp_dstaddr <= udev_req_srcaddr;
                           udev_resp_srcaddr <= udev_req_dstaddr;
                           udev_resp_valid   <= 1'b1;
                           udev_resp_cmd     <= resp_cmd_of(1'b0, req_size_s, req_len_s, DECERR);
                           udev_resp_data    <= '0;
                           state_r           <= RESP;
                        end else begin
                           state_r <= IDLE;
                        end
                     end
                     REQ_READ: begin
                        udev_req_ready    <= 1'b0;
                        udev_resp_dstaddr <= udev_req_srcaddr;
                        udev_resp_srcaddr <= udev_req_dstaddr;
                        if (req_ok_s) begin
                           axi_arvalid <= 1'b1;
                           axi_araddr  <= udev_req_dstaddr[31:0];
                           axi_arprot  <= 3'd0;
                           state_r     <= READ;
                        end else begin
                           udev_resp_valid <= 1'b1;
                           udev_resp_cmd   <= resp_cmd_of(1'b1, req_size_s, req_len_s, DECERR);
                           udev_resp_data  <= '0;
                           state_r         <= RESP;
                        end
                     end
                     default: state_r <= IDLE;
                  endcase
               end
            end
            WRITE: begin
               if (axi_awvalid && axi_awready) axi_awvalid <= 1'b0;
               if (axi_wvalid && axi_wready) axi_wvalid <= 1'b0;
               if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
                  axi_bready <= 1'b1;
                  state_r    <= WRESP;
               end
            end
            WRESP: begin
               if (axi_bvalid) begin
                  axi_bready <= 1'b0;
                  if (posted_r) begin
                     udev_req_ready <= 1'b1;
                     state_r        <= IDLE;
                  end else begin
                     udev_resp_valid <= 1'b1;
                     udev_resp_cmd   <= resp_cmd_of(1'b0, size_r, len_r, axi_bresp);
                     udev_resp_data  <= '0;
                     state_r         <= RESP;
                  end
               end
            end
            READ: begin
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  axi_rready  <= 1'b1;
                  state_r     <= RDATA;
               end
            end
            RDATA: begin
               if (axi_rvalid) begin
                  axi_rready      <= 1'b0;
                  udev_resp_valid <= 1'b1;
                  udev_resp_cmd   <= resp_cmd_of(1'b1, size_r, len_r, axi_rresp);
                  udev_resp_data  <= DW'(rdata_of(axi_rdata, size_r, lsb_r));
                  state_r         <= RESP;
               end
            end
            RESP: begin
               if (udev_resp_ready) begin
                  udev_resp_valid <= 1'b0;
                  udev_req_ready  <= 1'b1;
                  state_r         <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/umi2axilite.md
Name: umi2axilite

Overview:
- UMI device-side endpoint. Accepts single-word UMI read, write and posted-write requests from the switchboard fabric.
- Replays each request as one AXI-Lite master transaction toward a 32-bit peripheral or memory.
- Returns the matching UMI response.
- Mirror of the host-side AXI-Lite-to-UMI path: lets a switchboard testbench or remote host drive AXI-Lite slaves.

Parameters:
- DW, 32, UMI data width; only bits [31:0] are used.
- AW, 64, UMI address width.
- CW, 32, UMI command width.

Ports:
- clk  input  1  single clock
- nreset  input  1  asynchronous active-low reset
- udev_req_valid/ready  input/output  1/1  UMI request handshake
- udev_req_cmd  input  CW  UMI request command
- udev_req_dstaddr  input  AW  request target address
- udev_req_srcaddr  input  AW  request return address
- udev_req_data  input  DW  request write data
- udev_resp_valid/ready  output/input  1/1  UMI response handshake
- udev_resp_cmd  output  CW  response command
- udev_resp_dstaddr  output  AW  response target address
- udev_resp_srcaddr  output  AW  response source address
- udev_resp_data  output  DW  response read data
- axi_awvalid/awready  output/input  1/1; axi_awaddr  output  32; axi_awprot  output  3
- axi_wvalid/wready  output/input  1/1; axi_wdata  output  32; axi_wstrb  output  4
- axi_bvalid/bready  input/output  1/1; axi_bresp  input  2
- axi_arvalid/arready  output/input  1/1; axi_araddr  output  32; axi_arprot  output  3
- axi_rvalid/rready  input/output  1/1; axi_rdata  input  32; axi_rresp  input  2

Behaviour:
- Reset (async assert, sync deassert): state IDLE.
  - All valid outputs 0; udev_req_ready 0; bready/rready 0.
  - All address/data/cmd outputs 0.
  - Reset mid-transaction aborts it; no response is emitted.
- Command decode:
  - opcode = cmd[4:0]: REQ_READ 0x01, REQ_WRITE 0x03, REQ_POSTED 0x05.
  - size = cmd[7:5]; len = cmd[15:8].
  - Supported only when len==0 and size<=2.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - udev_req_ready=1. On req_valid&ready, latch cmd/dstaddr/srcaddr/data.
  - Next state: supported WRITE/POSTED -> WRITE; supported READ -> READ.
  - Unsupported READ/WRITE -> RESP with err=DECERR, no AXI traffic.
  - Any other opcode: dropped, stay IDLE.
  - ready is 0 in every other state, so only one request is outstanding.
- WRITE:
  - awvalid and wvalid assert in the cycle after acceptance.
  - Each valid drops independently on its own ready. Either handshake order is legal, including simultaneous.
  - awaddr = dstaddr[31:0]; awprot=0.
  - wstrb: size0 -> 4'b0001<<a; size1 -> 4'b0011<<a; size2 -> 4'hF, where a = dstaddr[1:0].
  - wdata = data[31:0] << 8*a.
  - Go to WRESP when both handshakes are done.
- WRESP:
  - bready=1. On bvalid: POSTED -> IDLE; WRITE -> RESP with err=bresp.
- READ: arvalid=1, araddr = dstaddr[31:0], arprot=0. On arready go to RDATA.
- RDATA:
  - rready=1. On rvalid, capture rdata >> 8*a.
  - Zero bytes above the requested size. err=rresp. Go to RESP.
- RESP:
  - udev_resp_valid=1, held stable until resp_ready, then IDLE.
  - resp_cmd: opcode RESP_READ 0x02 (for read) or RESP_WRITE 0x04 (for write); size and len echoed; cmd[22] (EOM)=1; cmd[26:25]=err; all other bits 0.
  - resp_dstaddr = req srcaddr; resp_srcaddr = req dstaddr.
  - resp_data = captured read data, 0 for writes.
- Latency with zero-wait AXI slave:
  - Read: request accept -> resp_valid in 3 cycles.
  - Write: request accept -> resp_valid in 3 cycles.
  - Next request accepted the cycle after the response handshake.
- Address wrap: bits above [31] are ignored. No burst or boundary splitting, since len must be 0.

Test Plan:
- WRITE dst=0x1000, data=0xDEADBEEF, size2, AXI slave zero-wait -> AW addr 0x1000, W data 0xDEADBEEF, wstrb 0xF; response opcode 0x04, err 0, resp_dstaddr = req srcaddr.
- READ dst=0x1002, size1, slave rdata=0xAABBCCDD -> araddr 0x1002; resp_data 0x0000AABB, opcode 0x02, size 1 echoed.
- POSTED dst=0x2001, size0, data=0x5A -> wstrb 0x2, wdata 0x00005A00; no UMI response; ready returns high after B.
- READ with len=3 -> no AR issued; response err=2'b11, data 0. Slave returns rresp=2'b10 on a legal read -> response err=2'b10.
- Backpressure: awready delayed 4 cycles while wready is immediate, and resp_ready held low 5 cycles -> each valid holds with stable payload; exactly one AW, one W and one response.
- Assert nreset while in RDATA -> all valids drop immediately. After release, a fresh READ completes normally with no stale response.
